// File: rtl/text_console_ctrl_pkg.sv
// Shared types and constants for the text console controller.
// Commands, FSM states, default geometry and the circular row-mapping helper.
package console_pkg;

  localparam int COLS_DEF   = 80;
  localparam int ROWS_DEF   = 60;
  localparam int CODE_W_DEF = 6;

  typedef enum logic [1:0] {
    CMD_PRINT   = 2'b00,
    CMD_NEWLINE = 2'b01,
    CMD_CLEAR   = 2'b10,
    CMD_HOME    = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WRITE     = 2'b01,
    ST_CLEAR_ROW = 2'b10,
    ST_CLEAR_ALL = 2'b11
  } state_t;

  // Logical row to physical row: add the top pointer, subtract ROWS once on overflow.
  function automatic logic [5:0] wrap_row(input logic [5:0] row, input logic [5:0] top,
                                          input logic [5:0] rows);
    logic [6:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= {1'b0, rows}) sum = sum - {1'b0, rows};
    return sum[5:0];
  endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// CPU command and VGA read bundle of the text console controller.
// master = command/read source, slave = controller.
interface text_console_ctrl_if #(parameter int CODE_W = console_pkg::CODE_W_DEF) ();
  import console_pkg::*;

  logic              cpu_valid;
  cmd_t              cpu_cmd;
  logic [CODE_W-1:0] cpu_char;
  logic              cpu_ready;
  logic              vid_re;
  logic [6:0]        vid_col;
  logic [5:0]        vid_row;
  logic [CODE_W-1:0] vid_code;
  logic              vid_valid;
  logic [6:0]        cur_col;
  logic [5:0]        cur_row;
  logic              busy;

  modport master (
    output cpu_valid, cpu_cmd, cpu_char, vid_re, vid_col, vid_row,
    input  cpu_ready, vid_code, vid_valid, cur_col, cur_row, busy
  );

  modport slave (
    input  cpu_valid, cpu_cmd, cpu_char, vid_re, vid_col, vid_row,
    output cpu_ready, vid_code, vid_valid, cur_col, cur_row, busy
  );

endinterface

// File: rtl/text_console_ctrl_ram.sv
// Single-port character buffer: synchronous write, registered read-first output.
// Contents are not reset; the controller clears them after reset.
module text_buf_ram #(
  parameter int DEPTH  = 4800,
  parameter int WIDTH  = 6,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/text_console_ctrl.sv
// Text console controller: cursor, circular-scroll character buffer, VGA-priority port arbitration.
//   state        | meaning
//   ST_IDLE      | ready for a command; NEWLINE/HOME resolve here in one cycle
//   ST_WRITE     | write latched char at cursor on first cycle without vid_re, then advance
//   ST_CLEAR_ROW | blank logical bottom row after a scroll, one cell per free cycle
//   ST_CLEAR_ALL | blank every cell in physical order, then home cursor and top
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter logic [CODE_W-1:0] BLANK_CODE = '0
) (
  input logic dclk,
  input logic clr,
  text_console_ctrl_if.slave bus
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
  localparam logic [5:0]        ROW_LAST  = 6'(ROWS - 1);
  localparam logic [5:0]        ROWS_V    = 6'(ROWS);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] CROW_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] phys, input logic [6:0] col);
    return ADDR_W'(phys) * COLS_A + ADDR_W'(col);
  endfunction

  state_t            state_q, state_d;
  logic [6:0]        cur_col_q, cur_col_d;
  logic [5:0]        cur_row_q, cur_row_d;
  logic [5:0]        top_q, top_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] char_q, char_d;
  logic              ready_q, ready_d;
  logic              vid_valid_q, vid_valid_d;
  logic [CODE_W-1:0] vid_hold_q, vid_hold_d;

  logic              accept;
  logic              line_feed;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [CODE_W-1:0] ram_wdata;
  logic [CODE_W-1:0] ram_rdata;
  logic [CODE_W-1:0] vid_code;

  assign accept = bus.cpu_valid & ready_q;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_CLEAR_ALL;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
      top_q       <= '0;
      cnt_q       <= '0;
      char_q      <= '0;
      ready_q     <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
      top_q       <= top_d;
      cnt_q       <= cnt_d;
      char_q      <= char_d;
      ready_q     <= ready_d;
      vid_valid_q <= vid_valid_d;
      vid_hold_q  <= vid_hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    char_d    = char_q;
    line_feed = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          case (bus.cpu_cmd)
            CMD_PRINT: begin
              char_d  = bus.cpu_char;
              state_d = ST_WRITE;
            end
            CMD_NEWLINE: begin
              cur_col_d = '0;
              line_feed = 1'b1;
            end
            CMD_CLEAR: state_d = ST_CLEAR_ALL;
            default: begin
              cur_col_d = '0;
              cur_row_d = '0;
            end
          endcase
        end
      end
      ST_WRITE: begin
        if (!bus.vid_re) begin
          if (cur_col_q == COL_LAST) begin
            cur_col_d = '0;
            line_feed = 1'b1;
          end else begin
            cur_col_d = cur_col_q + 7'd1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_CLEAR_ROW: begin
        if (!bus.vid_re) begin
          if (cnt_q == CROW_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        if (!bus.vid_re) begin
          if (cnt_q == CELL_LAST) begin
            cnt_d     = '0;
            top_d     = '0;
            cur_col_d = '0;
            cur_row_d = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
    endcase
    // Bottom row scrolls: advance top so the oldest row becomes the new bottom, then blank it.
    if (line_feed) begin
      if (cur_row_q == ROW_LAST) begin
        top_d   = (top_q == ROW_LAST) ? 6'd0 : top_q + 6'd1;
        state_d = ST_CLEAR_ROW;
      end else begin
        cur_row_d = cur_row_q + 6'd1;
        state_d   = ST_IDLE;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = cell_addr(wrap_row(bus.vid_row, top_q, ROWS_V), bus.vid_col);
    ram_wdata = BLANK_CODE;
    if (!bus.vid_re) begin
      case (state_q)
        ST_WRITE: begin
          ram_we    = 1'b1;
          ram_addr  = cell_addr(wrap_row(cur_row_q, top_q, ROWS_V), cur_col_q);
          ram_wdata = char_q;
        end
        ST_CLEAR_ROW: begin
          ram_we   = 1'b1;
          ram_addr = cell_addr(wrap_row(ROW_LAST, top_q, ROWS_V), cnt_q[6:0]);
        end
        ST_CLEAR_ALL: begin
          ram_we   = 1'b1;
          ram_addr = cnt_q;
        end
        default: ram_we = 1'b0;
      endcase
    end
    ready_d     = (state_d == ST_IDLE) && !accept;
    vid_valid_d = bus.vid_re;
    vid_hold_d  = vid_code;
  end

  text_buf_ram #(
    .DEPTH (CELLS),
    .WIDTH (CODE_W),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk  (dclk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // RAM output is only meaningful right after a video read; otherwise show the last read.
  assign vid_code      = vid_valid_q ? ram_rdata : vid_hold_q;
  assign bus.vid_code  = vid_code;
  assign bus.vid_valid = vid_valid_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cur_col   = cur_col_q;
  assign bus.cur_row   = cur_row_q;
  assign bus.busy      = (state_q == ST_CLEAR_ROW) || (state_q == ST_CLEAR_ALL);

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: directed table, multi-cycle corner sequences, and
// randomized commands checked against a row-shifting screen model.
module tb_text_console_ctrl;
  import console_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic dclk = 1'b0;
  logic clr;

  text_console_ctrl_if bus_if ();

  text_console_ctrl dut (
    .dclk(dclk),
    .clr (clr),
    .bus (bus_if)
  );

  always #5 dclk = ~dclk;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] mdl [ROWS][COLS];
  int m_col, m_row;

  typedef struct {
    logic [1:0] cmd;
    logic [5:0] ch;
    int         col;
    int         row;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = 6'd0;
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_lf();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) mdl[r][c] = mdl[r+1][c];
      for (int c = 0; c < COLS; c++) mdl[ROWS-1][c] = 6'd0;
    end
  endtask

  task automatic model_apply(input logic [1:0] cmd, input logic [5:0] ch);
    case (cmd)
      2'b00: begin
        mdl[m_row][m_col] = ch;
        if (m_col == COLS - 1) begin
          m_col = 0;
          model_lf();
        end else m_col++;
      end
      2'b01: begin
        m_col = 0;
        model_lf();
      end
      2'b10: model_clear();
      default: begin
        m_col = 0;
        m_row = 0;
      end
    endcase
  endtask

  task automatic drive_vid(input bit rnd);
    if (rnd && $urandom_range(0, 1) == 1) begin
      bus_if.vid_re  = 1'b1;
      bus_if.vid_col = 7'($urandom_range(0, COLS - 1));
      bus_if.vid_row = 6'($urandom_range(0, ROWS - 1));
    end else bus_if.vid_re = 1'b0;
  endtask

  task automatic wait_ready(input bit rnd, input string name);
    int n = 0;
    while (bus_if.cpu_ready !== 1'b1 && n < 20000) begin
      drive_vid(rnd);
      @(negedge dclk);
      n++;
    end
    bus_if.vid_re = 1'b0;
    if (n >= 20000) check({name, " timeout"}, int'(bus_if.cpu_ready), 1);
  endtask

  task automatic send_cmd(input logic [1:0] cmd, input logic [5:0] ch, input bit rnd);
    wait_ready(rnd, "ready_before");
    bus_if.cpu_valid = 1'b1;
    bus_if.cpu_cmd   = cmd_t'(cmd);
    bus_if.cpu_char  = ch;
    drive_vid(rnd);
    @(negedge dclk);
    bus_if.cpu_valid = 1'b0;
    bus_if.vid_re    = 1'b0;
    check("ready_drop", int'(bus_if.cpu_ready), 0);
    model_apply(cmd, ch);
    wait_ready(rnd, "ready_after");
  endtask

  task automatic read_check(input int col, input int row, input int exp, input string name);
    bus_if.vid_re  = 1'b1;
    bus_if.vid_col = 7'(col);
    bus_if.vid_row = 6'(row);
    @(negedge dclk);
    bus_if.vid_re = 1'b0;
    check({name, " valid"}, int'(bus_if.vid_valid), 1);
    check(name, int'(bus_if.vid_code), exp);
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, " col"}, int'(bus_if.cur_col), col);
    check({name, " row"}, int'(bus_if.cur_row), row);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " ready"}, int'(bus_if.cpu_ready), 0);
    check({name, " vid_valid"}, int'(bus_if.vid_valid), 0);
    check({name, " vid_code"}, int'(bus_if.vid_code), 0);
    check_cursor(name, 0, 0);
    check({name, " busy"}, int'(bus_if.busy), 1);
  endtask

  task automatic count_clear_all(input string name);
    int n = 0;
    while (bus_if.cpu_ready !== 1'b1 && n < 6000) begin
      @(negedge dclk);
      n++;
      if (n == 2400) check({name, " busy_mid"}, int'(bus_if.busy), 1);
    end
    check({name, " cycles"}, n, 4800);
    check({name, " busy_end"}, int'(bus_if.busy), 0);
    check_cursor(name, 0, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int clears;
    logic [1:0] rc;
    logic [5:0] rch;

    tbl[0] = '{2'b00, 6'd1, 1, 0};
    tbl[1] = '{2'b00, 6'd2, 2, 0};
    tbl[2] = '{2'b01, 6'd0, 0, 1};
    tbl[3] = '{2'b00, 6'd3, 1, 1};
    tbl[4] = '{2'b11, 6'd0, 0, 0};
    tbl[5] = '{2'b01, 6'd0, 0, 1};
    tbl[6] = '{2'b01, 6'd0, 0, 2};

    clr              = 1'b1;
    bus_if.cpu_valid = 1'b0;
    bus_if.cpu_cmd   = CMD_PRINT;
    bus_if.cpu_char  = '0;
    bus_if.vid_re    = 1'b0;
    bus_if.vid_col   = '0;
    bus_if.vid_row   = '0;
    model_clear();

    // Reset and initial clear
    repeat (3) @(negedge dclk);
    check_reset_outputs("reset");
    clr = 1'b0;
    count_clear_all("clear_all");
    read_check(5, 7, 0, "rd_5_7");

    // Directed command table
    for (int i = 0; i < 7; i++) begin
      send_cmd(tbl[i].cmd, tbl[i].ch, 1'b1);
      check_cursor($sformatf("tbl%0d", i), tbl[i].col, tbl[i].row);
    end
    read_check(0, 0, 1, "rd_0_0");
    read_check(1, 0, 2, "rd_1_0");
    read_check(0, 1, 3, "rd_0_1");
    @(negedge dclk);
    check("hold valid", int'(bus_if.vid_valid), 0);
    check("hold code", int'(bus_if.vid_code), 3);

    // Line wrap at column 79
    send_cmd(2'b01, 6'd0, 1'b1);
    check_cursor("nl_row3", 0, 3);
    for (int i = 0; i < COLS - 1; i++) send_cmd(2'b00, 6'($urandom_range(1, 63)), 1'b1);
    check_cursor("at_79_3", 79, 3);
    send_cmd(2'b00, 6'd2, 1'b1);
    check_cursor("wrap", 0, 4);
    read_check(79, 3, 2, "rd_79_3");
    read_check(0, 3, int'(mdl[3][0]), "rd_0_3");

    // Scroll from the bottom row
    for (int i = 0; i < 55; i++) send_cmd(2'b01, 6'd0, 1'b1);
    check_cursor("row59", 0, 59);
    wait_ready(1'b0, "scroll_ready");
    bus_if.cpu_valid = 1'b1;
    bus_if.cpu_cmd   = CMD_NEWLINE;
    @(negedge dclk);
    bus_if.cpu_valid = 1'b0;
    model_apply(2'b01, 6'd0);
    n = 0;
    while (bus_if.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge dclk);
    end
    check("scroll busy cycles", n, 80);
    check("scroll ready", int'(bus_if.cpu_ready), 1);
    check_cursor("scroll", 0, 59);
    read_check(0, 0, 3, "scroll rd_0_0");
    read_check(79, 2, 2, "scroll rd_79_2");
    for (int c = 0; c < COLS; c++) read_check(c, 59, 0, $sformatf("row59 c%0d", c));

    // Write stalled by 20 cycles of video reads
    bus_if.cpu_valid = 1'b1;
    bus_if.cpu_cmd   = CMD_PRINT;
    bus_if.cpu_char  = 6'd4;
    bus_if.vid_re    = 1'b1;
    bus_if.vid_col   = 7'd0;
    bus_if.vid_row   = 6'd0;
    @(negedge dclk);
    bus_if.cpu_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("stall%0d ready", i), int'(bus_if.cpu_ready), 0);
      check($sformatf("stall%0d vid", i), int'(bus_if.vid_code), 3);
      @(negedge dclk);
    end
    bus_if.vid_re = 1'b0;
    check_cursor("stalled", 0, 59);
    @(negedge dclk);
    model_apply(2'b00, 6'd4);
    check("stall release ready", int'(bus_if.cpu_ready), 1);
    check_cursor("stall done", 1, 59);
    read_check(0, 59, 4, "rd_0_59");

    // Reset in the middle of a row clear
    wait_ready(1'b0, "mid_ready");
    bus_if.cpu_valid = 1'b1;
    bus_if.cpu_cmd   = CMD_NEWLINE;
    @(negedge dclk);
    bus_if.cpu_valid = 1'b0;
    repeat (40) @(negedge dclk);
    check("mid busy", int'(bus_if.busy), 1);
    clr = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge dclk);
    clr = 1'b0;
    model_clear();
    count_clear_all("reclear");
    read_check(0, 0, 0, "reclear rd_0_0");
    read_check(79, 2, 0, "reclear rd_79_2");
    send_cmd(2'b00, 6'd5, 1'b0);
    check_cursor("post reclear", 1, 0);
    read_check(0, 0, 5, "post reclear rd");

    // Randomized commands against the model
    clears = 0;
    for (int i = 0; i < 500; i++) begin
      n = $urandom_range(0, 99);
      rch = 6'($urandom_range(0, 63));
      if (n < 60) rc = 2'b00;
      else if (n < 92) rc = 2'b01;
      else if (n < 98 || clears >= 2) rc = 2'b11;
      else begin
        rc = 2'b10;
        clears++;
      end
      send_cmd(rc, rch, 1'b1);
      check_cursor($sformatf("rnd%0d", i), m_col, m_row);
    end
    for (int i = 0; i < 100; i++) begin
      int c, r;
      c = $urandom_range(0, COLS - 1);
      r = $urandom_range(0, ROWS - 1);
      read_check(c, r, int'(mdl[r][c]), $sformatf("rnd rd (%0d,%0d)", c, r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
